// File: rtl/seven_seg_scan_ctrl_if.sv
// Staging-side bus of the seven-segment scan controller: display data, load strobe and
// the pending flag that reports data waiting for the next frame boundary.
interface seven_seg_scan_ctrl_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;
    logic        pending;

    modport master (
        output value,
        output dp,
        output blank,
        output load,
        input  pending
    );

    modport slave (
        input  value,
        input  dp,
        input  blank,
        input  load,
        output pending
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with double-buffered data that is swapped
// only at frame boundaries, so a frame never mixes old and new digits.
module seven_seg_scan_ctrl #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  dp_n
);
    localparam int unsigned   PW        = $clog2(TICKS_PER_DIGIT);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_DIGIT - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_TICKS);

    logic [PW-1:0] presc_q;
    logic [1:0]    digit_q;
    logic [15:0]   stg_value_q, act_value_q;
    logic [3:0]    stg_dp_q, act_dp_q;
    logic [3:0]    stg_blank_q, act_blank_q;
    logic          pending_q;

    logic          slot_end, frame_end, dark;
    logic [3:0]    nibble;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_n_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign bus.pending = pending_q;

    always_comb begin
        slot_end  = (presc_q == PRESC_MAX);
        frame_end = slot_end && (digit_q == 2'd3);
        nibble    = act_value_q[{digit_q, 2'b00} +: 4];
        // Blank window at slot start keeps the previous digit's segments from ghosting.
        dark      = (presc_q < BLANK_END) || act_blank_q[digit_q];
        an_d      = 4'hF;
        seg_d     = 7'h7F;
        dp_n_d    = 1'b1;
        if (!dark) begin
            an_d   = ~(4'b0001 << digit_q);
            seg_d  = hex_to_seg(nibble);
            dp_n_d = ~act_dp_q[digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            digit_q     <= '0;
            stg_value_q <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '0;
            act_value_q <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            pending_q   <= 1'b0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
        end else begin
            presc_q <= slot_end ? '0 : presc_q + 1'b1;
            if (slot_end) begin
                digit_q <= digit_q + 2'd1;
            end
            if (frame_end && pending_q) begin
                act_value_q <= stg_value_q;
                act_dp_q    <= stg_dp_q;
                act_blank_q <= stg_blank_q;
                pending_q   <= 1'b0;
            end
            // A load on the boundary cycle refills staging after the old contents moved out.
            if (bus.load) begin
                stg_value_q <= bus.value;
                stg_dp_q    <= bus.dp;
                stg_blank_q <= bus.blank;
                pending_q   <= 1'b1;
            end
            an   <= an_d;
            seg  <= seg_d;
            dp_n <= dp_n_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 8-cycle slots and a 2-cycle blank window.
module tb_seven_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;

    int checks = 0;
    int errors = 0;
    int k = -1;

    localparam logic [27:0] SZERO = {4{7'h40}};
    localparam logic [27:0] S1A2F = {7'h79, 7'h08, 7'h24, 7'h0E};
    localparam logic [27:0] S2222 = {4{7'h24}};
    localparam logic [27:0] S5555 = {4{7'h12}};
    localparam logic [27:0] S3333 = {4{7'h30}};
    localparam logic [27:0] S4321 = {7'h19, 7'h30, 7'h24, 7'h79};

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .an   (an),
        .seg  (seg),
        .dp_n (dp_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // k counts edges since reset release; outputs after edge k show slot phase k%8 of digit (k/8)%4.
    task automatic check_cycle(input logic [27:0] segs, input logic [3:0] dps,
                               input logic [3:0] blk);
        int         p;
        int         d;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        p  = k % 8;
        d  = (k / 8) % 4;
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
        if (p >= 2 && !blk[d]) begin
            ea[d] = 1'b0;
            es    = segs[d*7 +: 7];
            ed    = ~dps[d];
        end
        chk($sformatf("an@%0d", k), 32'(an), 32'(ea));
        chk($sformatf("seg@%0d", k), 32'(seg), 32'(es));
        chk($sformatf("dp_n@%0d", k), 32'(dp_n), 32'(ed));
    endtask

    task automatic run(input int n, input logic [27:0] segs, input logic [3:0] dps,
                       input logic [3:0] blk);
        repeat (n) begin
            step();
            check_cycle(segs, dps, blk);
        end
    endtask

    task automatic load_cycle(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                              input logic [27:0] segs, input logic [3:0] dps,
                              input logic [3:0] blk);
        bus.value = v;
        bus.dp    = d;
        bus.blank = b;
        bus.load  = 1'b1;
        step();
        check_cycle(segs, dps, blk);
        bus.load  = 1'b0;
        chk($sformatf("pending_set@%0d", k), 32'(bus.pending), 32'd1);
    endtask

    initial begin
        bus.value = '0;
        bus.dp    = '0;
        bus.blank = '0;
        bus.load  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'd1);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        rst = 1'b0;

        // Free run after reset: all digits show "0".
        run(64, SZERO, 4'b0000, 4'b0000);

        // Mid-frame load shows up only from the next frame.
        run(6, SZERO, 4'b0000, 4'b0000);
        load_cycle(16'h1A2F, 4'b0100, 4'b0000, SZERO, 4'b0000, 4'b0000);
        run(25, SZERO, 4'b0000, 4'b0000);
        chk("pending_clr_1a2f", 32'(bus.pending), 32'd0);
        run(32, S1A2F, 4'b0100, 4'b0000);

        // Two loads in one frame: last one wins.
        run(3, S1A2F, 4'b0100, 4'b0000);
        load_cycle(16'h1111, 4'b0000, 4'b0000, S1A2F, 4'b0100, 4'b0000);
        run(3, S1A2F, 4'b0100, 4'b0000);
        load_cycle(16'h2222, 4'b0000, 4'b0000, S1A2F, 4'b0100, 4'b0000);
        run(24, S1A2F, 4'b0100, 4'b0000);
        chk("pending_clr_2222", 32'(bus.pending), 32'd0);
        run(32, S2222, 4'b0000, 4'b0000);

        // Load coincident with the frame boundary while data is pending.
        run(4, S2222, 4'b0000, 4'b0000);
        load_cycle(16'h5555, 4'b0000, 4'b0000, S2222, 4'b0000, 4'b0000);
        run(26, S2222, 4'b0000, 4'b0000);
        load_cycle(16'h3333, 4'b0000, 4'b0000, S2222, 4'b0000, 4'b0000);
        run(31, S5555, 4'b0000, 4'b0000);
        chk("pending_hold_3333", 32'(bus.pending), 32'd1);
        run(1, S5555, 4'b0000, 4'b0000);
        chk("pending_clr_3333", 32'(bus.pending), 32'd0);
        run(32, S3333, 4'b0000, 4'b0000);

        // Per-digit blanking of digits 1 and 3.
        run(2, S3333, 4'b0000, 4'b0000);
        load_cycle(16'h4321, 4'b0000, 4'b1010, S3333, 4'b0000, 4'b0000);
        run(29, S3333, 4'b0000, 4'b0000);
        run(32, S4321, 4'b0000, 4'b1010);

        // Reset during digit 2 with data pending; a simultaneous load must lose.
        run(2, S4321, 4'b0000, 4'b1010);
        load_cycle(16'h8888, 4'b0000, 4'b0000, S4321, 4'b0000, 4'b1010);
        run(16, S4321, 4'b0000, 4'b1010);
        chk("pre_rst_an", 32'(an), 32'hB);
        rst       = 1'b1;
        bus.value = 16'h9999;
        bus.load  = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp_n", 32'(dp_n), 32'd1);
        chk("mid_rst_pending", 32'(bus.pending), 32'd0);
        rst      = 1'b0;
        bus.load = 1'b0;
        k        = -1;
        run(32, SZERO, 4'b0000, 4'b0000);
        chk("post_rst_pending", 32'(bus.pending), 32'd0);
        run(32, SZERO, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
